// File: rtl/stream_handshake_monitor.sv
// stream_handshake_monitor: passive valid/ready checker with per-channel counters, sticky errors and first-error capture.
// Stall timeout detection is built only when COMMON_CELLS_STREAM_MON_TIMEOUT_EN is defined.
module stream_handshake_monitor #(
  parameter int NumChannels = 4,
  parameter int DataWidth = 32,
  parameter int CntWidth = 16,
  parameter int TimeoutCycles = 256,
  localparam int ChanWidth = NumChannels > 1 ? $clog2(NumChannels) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic [NumChannels-1:0]          valid_i,
  input  logic [NumChannels-1:0]          ready_i,
  input  logic [NumChannels*DataWidth-1:0] data_i,
  output logic [NumChannels*CntWidth-1:0] transfer_cnt_o,
  output logic [NumChannels*CntWidth-1:0] stall_cnt_o,
  output logic [NumChannels-1:0]          err_valid_drop_o,
  output logic [NumChannels-1:0]          err_data_change_o,
  output logic [NumChannels-1:0]          err_timeout_o,
  output logic                            err_any_o,
  output logic                            first_err_valid_o,
  output logic [ChanWidth-1:0]            first_err_chan_o,
  output logic [1:0]                      first_err_code_o
);
  if (NumChannels < 1 || NumChannels > 32 || TimeoutCycles < 1) begin : g_bad_param
    $error("stream_handshake_monitor: parameter out of range");
  end
  logic [NumChannels-1:0] xfer, stall, drop_ev, chg_ev, to_ev, prev_stall_q;
  logic [NumChannels-1:0] err_drop_q, err_chg_q, err_to_q;
  logic [DataWidth-1:0]   prev_data_q [NumChannels];
  logic [CntWidth-1:0]    xfer_cnt_q [NumChannels];
  logic [CntWidth-1:0]    stall_cnt_q [NumChannels];
  logic                   err_any_q, first_valid_q, ev_any;
  logic [ChanWidth-1:0]   first_chan_q, ev_chan;
  logic [1:0]             first_code_q, ev_code;
  assign xfer  = valid_i & ready_i;
  assign stall = valid_i & ~ready_i;
  always_comb begin
    drop_ev = '0;
    chg_ev  = '0;
    for (int i = 0; i < NumChannels; i++) begin
      drop_ev[i] = prev_stall_q[i] & ~valid_i[i];
      chg_ev[i]  = prev_stall_q[i] & valid_i[i] & (data_i[i*DataWidth +: DataWidth] != prev_data_q[i]);
    end
  end
`ifdef COMMON_CELLS_STREAM_MON_TIMEOUT_EN
  localparam int RunWidth = $clog2(TimeoutCycles + 1);
  localparam logic [RunWidth-1:0] RunMax = RunWidth'(TimeoutCycles);
  logic [RunWidth-1:0] run_q [NumChannels];
  // flag fires on the stall that brings the run length up to TimeoutCycles
  always_comb begin
    to_ev = '0;
    for (int i = 0; i < NumChannels; i++)
      to_ev[i] = stall[i] & (run_q[i] >= RunMax - RunWidth'(1));
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumChannels; i++)
      run_q[i] <= (rst_i || clear_i || !stall[i]) ? '0 :
                  (run_q[i] == RunMax) ? RunMax : run_q[i] + RunWidth'(1);
  end
`else
  assign to_ev = '0;
`endif
  // lowest channel wins, then lowest code; scanning downward lets the lowest index overwrite last
  always_comb begin
    ev_chan = '0;
    ev_code = '0;
    for (int i = NumChannels - 1; i >= 0; i--)
      if (drop_ev[i] | chg_ev[i] | to_ev[i]) begin
        ev_chan = ChanWidth'(i);
        ev_code = drop_ev[i] ? 2'd1 : chg_ev[i] ? 2'd2 : 2'd3;
      end
  end
  assign ev_any = |{drop_ev, chg_ev, to_ev};
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      prev_stall_q  <= '0;
      err_drop_q    <= '0;
      err_chg_q     <= '0;
      err_to_q      <= '0;
      err_any_q     <= 1'b0;
      first_valid_q <= 1'b0;
      first_chan_q  <= '0;
      first_code_q  <= '0;
      for (int i = 0; i < NumChannels; i++) begin
        prev_data_q[i] <= '0;
        xfer_cnt_q[i]  <= '0;
        stall_cnt_q[i] <= '0;
      end
    end else begin
      prev_stall_q <= stall;
      err_drop_q   <= err_drop_q | drop_ev;
      err_chg_q    <= err_chg_q | chg_ev;
      err_to_q     <= err_to_q | to_ev;
      err_any_q    <= err_any_q | ev_any;
      if (!first_valid_q && ev_any) begin
        first_valid_q <= 1'b1;
        first_chan_q  <= ev_chan;
        first_code_q  <= ev_code;
      end
      for (int i = 0; i < NumChannels; i++) begin
        if (stall[i]) prev_data_q[i] <= data_i[i*DataWidth +: DataWidth];
        if (xfer[i] && xfer_cnt_q[i] != '1) xfer_cnt_q[i] <= xfer_cnt_q[i] + CntWidth'(1);
        if (stall[i] && stall_cnt_q[i] != '1) stall_cnt_q[i] <= stall_cnt_q[i] + CntWidth'(1);
      end
    end
  end
  for (genvar g = 0; g < NumChannels; g++) begin : g_pack
    assign transfer_cnt_o[g*CntWidth +: CntWidth] = xfer_cnt_q[g];
    assign stall_cnt_o[g*CntWidth +: CntWidth]    = stall_cnt_q[g];
  end
  assign err_valid_drop_o  = err_drop_q;
  assign err_data_change_o = err_chg_q;
  assign err_timeout_o     = err_to_q;
  assign err_any_o         = err_any_q;
  assign first_err_valid_o = first_valid_q;
  assign first_err_chan_o  = first_chan_q;
  assign first_err_code_o  = first_code_q;
endmodule
